// File: rtl/mult_pkg.sv
// Shared types for the Booth multiplier slice: FSM states, the Booth recode
// operations, and the iteration-count helper used by the top.
// No ports; imported with "import mult_pkg::*;".
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Partial-product selection for one radix-4 step.
  typedef enum logic [2:0] {
    OP_ZERO,
    OP_PM,
    OP_P2M,
    OP_NM,
    OP_N2M
  } booth_op_e;

  localparam int MULT_WIDTH_DFLT = 32;
  localparam int ITER            = MULT_WIDTH_DFLT / 2;

  // Radix-4 retires two multiplier bits per iteration.
  function automatic int iter_count(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to a partial-product op.
// Latency: purely combinational.
// Backpressure: none; the output follows the input.
// Ports: window (3 LSBs of the product register), op (selected multiple),
//        neg (1 when the multiple is subtracted; drives the adder carry-in).
module booth_recode
  import mult_pkg::*;
(
  input  logic [2:0] window,
  output booth_op_e  op,
  output logic       neg
);

  always_comb begin
    op  = OP_ZERO;
    neg = 1'b0;
    case (window)
      3'b001, 3'b010: op = OP_PM;
      3'b011:         op = OP_P2M;
      3'b100: begin
        op  = OP_N2M;
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        op  = OP_NM;
        neg = 1'b1;
      end
      default:        op = OP_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mult.sv
// Iterative signed radix-4 Booth multiplier (low WIDTH product bits + overflow flag).
// Latency: start sampled at edge k -> result_rdy in the cycle after edge k+WIDTH/2.
// Backpressure: none; busy is high in RUN and starts seen while busy are dropped.
// Ports: clock, reset (async active-low), ctrl_start, operand_a, operand_b,
//        busy, result_rdy (1-cycle pulse), result, exception (signed overflow).
// Optional: define MULT_EARLY_TERM_EN to finish as soon as the remaining
//           multiplier bits recode to zero (1..WIDTH/2 RUN cycles).
module booth_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             result_rdy,
  output logic [WIDTH-1:0] result,
  output logic             exception
);

  // Product register: {accumulator (WIDTH+2), multiplier (WIDTH), guard bit}.
  localparam int AW     = WIDTH + 2;
  localparam int PW     = 2 * WIDTH + 3;
  localparam int N_ITER = iter_count(WIDTH);

  state_e           state_q, state_nxt;
  logic [AW-1:0]    m_q;
  logic [PW-1:0]    p_q, p_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;

  logic             load;
  logic             done_wr;

  booth_op_e        op;
  logic             neg;
  logic [AW-1:0]    mag;
  logic [AW-1:0]    addend;
  logic [AW-1:0]    acc;
  logic [PW-1:0]    p_add;
  logic [PW-1:0]    p_step;
  logic [PW-1:0]    p_run;
  logic             last_iter;
  logic             finish;
  logic [WIDTH:0]   prod_hi;

  booth_recode u_recode (
    .window (p_q[2:0]),
    .op     (op),
    .neg    (neg)
  );

  always_comb begin
    mag = '0;
    case (op)
      OP_PM, OP_NM:   mag = m_q;
      OP_P2M, OP_N2M: mag = {m_q[AW-2:0], 1'b0};
      default:        mag = '0;
    endcase
  end

  // Subtraction as invert plus carry-in; the WIDTH+2 add wraps by design.
  assign addend    = neg ? ~mag : mag;
  assign acc       = p_q[PW-1:WIDTH+1] + addend + AW'(neg);
  assign p_add     = {acc, p_q[WIDTH:0]};
  assign p_step    = {{2{p_add[PW-1]}}, p_add[PW-1:2]};
  assign last_iter = (cnt_q == CNT_W'(N_ITER - 1));

`ifdef MULT_EARLY_TERM_EN
  // After cnt_q iterations the unconsumed multiplier bits plus guard sit in
  // p_q[WIDTH-2*cnt_q:0]. If they are uniform every remaining step adds zero,
  // so the remaining shifts collapse into one arithmetic shift.
  logic [WIDTH:0]   rem_mask;
  logic [WIDTH:0]   rem_bits;
  logic             rem_flat;
  logic [CNT_W+1:0] skip_sh;
  logic [PW-1:0]    p_skip;

  assign rem_mask = {(WIDTH+1){1'b1}} >> {cnt_q, 1'b0};
  assign rem_bits = p_q[WIDTH:0] & rem_mask;
  assign rem_flat = (rem_bits == '0) || (rem_bits == rem_mask);
  assign skip_sh  = {(CNT_W+1)'(N_ITER) - {1'b0, cnt_q}, 1'b0};
  assign p_skip   = $signed(p_q) >>> skip_sh;
  assign finish   = rem_flat | last_iter;
  assign p_run    = rem_flat ? p_skip : p_step;
`else
  assign finish   = last_iter;
  assign p_run    = p_step;
`endif

  // Product bits [2*WIDTH-1:WIDTH-1] of the finished product.
  assign prod_hi = p_run[2*WIDTH:WIDTH];

  always_comb begin
    state_nxt = state_q;
    p_nxt     = p_q;
    cnt_nxt   = cnt_q;
    load      = 1'b0;
    done_wr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        p_nxt   = p_run;
        cnt_nxt = cnt_q + 1'b1;
        if (finish) begin
          state_nxt = DONE;
          done_wr   = 1'b1;
        end
      end
      DONE: begin
        if (ctrl_start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) begin
      p_nxt   = {{AW{1'b0}}, operand_b, 1'b0};
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      p_q     <= p_nxt;
      cnt_q   <= cnt_nxt;
      if (load) begin
        m_q <= {{2{operand_a[WIDTH-1]}}, operand_a};
      end
    end
  end

  // Result registers are written on the edge into DONE and hold until the next.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      exc_q    <= 1'b0;
    end else if (done_wr) begin
      result_q <= p_run[WIDTH:1];
      exc_q    <= ~((&prod_hi) | ~(|prod_hi));
    end
  end

  assign busy       = (state_q == RUN);
  assign result_rdy = (state_q == DONE);
  assign result     = result_q;
  assign exception  = exc_q;

endmodule

// File: tb/tb_booth_mult.sv
module tb_booth_mult;

  localparam int W    = 32;
  localparam int ITER = W / 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ctrl_start = 1'b0;
  logic [W-1:0]  operand_a = '0;
  logic [W-1:0]  operand_b = '0;
  logic          busy;
  logic          result_rdy;
  logic [W-1:0]  result;
  logic          exception;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  booth_mult #(.WIDTH(W), .CNT_W(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .ctrl_start (ctrl_start),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .busy       (busy),
    .result_rdy (result_rdy),
    .result     (result),
    .exception  (exception)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Number of RUN cycles an operation takes, from the multiplier value alone.
  function automatic int run_cycles(input logic [W-1:0] b);
`ifdef MULT_EARLY_TERM_EN
    logic [W:0] w;
    bit         flat;
    w = {b, 1'b0};
    for (int j = 0; j < ITER; j++) begin
      flat = 1'b1;
      for (int k = 2 * j; k <= W; k++) begin
        if (w[k] != w[W]) flat = 1'b0;
      end
      if (flat) return j + 1;
    end
    return ITER;
`else
    return ITER + (b == b ? 0 : 1);
`endif
  endfunction

  // Reference model: timestamps of the current operation plus held outputs.
  int          cyc       = 0;
  int          run_start = -1000;
  int          run_end   = -1000;
  int          rdy_cyc   = -1000;
  logic [W-1:0] held_res = '0;
  logic         held_exc = 1'b0;
  logic [W-1:0] pend_res = '0;
  logic         pend_exc = 1'b0;

  always @(posedge clock or negedge reset) begin
    longint prod;
    int     lat;
    if (!reset) begin
      run_start = -1000;
      run_end   = -1000;
      rdy_cyc   = -1000;
      held_res  = '0;
      held_exc  = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (cyc == rdy_cyc) begin
        held_res = pend_res;
        held_exc = pend_exc;
      end
      if (ctrl_start === 1'b1 && !((cyc - 1) >= run_start && (cyc - 1) <= run_end)) begin
        lat       = run_cycles(operand_b);
        prod      = longint'($signed(operand_a)) * longint'($signed(operand_b));
        pend_res  = prod[W-1:0];
        pend_exc  = (prod > 64'sd2147483647) || (prod < -64'sd2147483648);
        run_start = cyc;
        run_end   = cyc + lat - 1;
        rdy_cyc   = cyc + lat;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy",       64'(busy),       64'(cyc >= run_start && cyc <= run_end));
      chk("result_rdy", 64'(result_rdy), 64'(cyc == rdy_cyc));
      chk("result",     64'(result),     64'(held_res));
      chk("exception",  64'(exception),  64'(held_exc));
    end
  end

  // Called right after a negedge: drives one start, returns the negedge count
  // until result_rdy (0 if it never came). Optionally injects ignored starts.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit spur, output int lat);
    bit found;
    operand_a  = a;
    operand_b  = b;
    ctrl_start = 1'b1;
    @(negedge clock);
    ctrl_start = 1'b0;
    operand_a  = $urandom;
    operand_b  = $urandom;
    lat   = 0;
    found = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      ctrl_start = 1'b0;
      if (result_rdy) begin
        lat   = i;
        found = 1'b1;
        break;
      end
      if (spur && $urandom_range(0, 7) == 0) begin
        ctrl_start = 1'b1;
        operand_a  = $urandom;
        operand_b  = $urandom;
      end
      @(negedge clock);
    end
    chk("done_within_bound", 64'(found), 64'(1));
  endtask

  task automatic do_lit(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ee);
    int lat;
    issue(a, b, 1'b0, lat);
    chk({nm, "_result"},    64'(result),    64'(er));
    chk({nm, "_exception"}, 64'(exception), 64'(ee));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 15));
      5:       return 32'(0) - 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int n_rdy;
    logic [W-1:0] got_r;

    #2 reset = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset_busy",       64'(busy),       64'(0));
    chk("reset_result_rdy", 64'(result_rdy), 64'(0));
    chk("reset_result",     64'(result),     64'(0));
    chk("reset_exception",  64'(exception),  64'(0));
    reset = 1'b1;
    @(negedge clock);

    // Hand-computed products.
    issue(32'd3, 32'd4, 1'b0, lat);
    chk("3x4_result",    64'(result),    64'h0000_000C);
    chk("3x4_exception", 64'(exception), 64'(0));
`ifndef MULT_EARLY_TERM_EN
    chk("3x4_latency",   64'(lat),       64'(17));
`endif
    repeat (2) @(negedge clock);
    do_lit("m7x6",     32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFD6, 1'b0);
    do_lit("maxx2",    32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b1);
    do_lit("minxm1",   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    do_lit("2p16sq",   32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    do_lit("zero",     32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0);
    @(negedge clock);

    // Starts during RUN are dropped; a start held in DONE is taken back-to-back.
    operand_a  = 32'd3;
    operand_b  = 32'h4000_0001;
    ctrl_start = 1'b1;
    @(negedge clock);
    ctrl_start = 1'b0;
    n_rdy = 0;
    got_r = '0;
    for (int i = 1; i <= 17; i++) begin
      ctrl_start = (i == 5 || i == 10);
      if (ctrl_start) begin
        operand_a = $urandom;
        operand_b = $urandom;
      end
      if (result_rdy) begin
        n_rdy++;
        got_r = result;
      end
      if (i < 17) @(negedge clock);
    end
    chk("ignored_rdy_count", 64'(n_rdy),     64'(1));
    chk("ignored_result",    64'(got_r),     64'hC000_0003);
    chk("ignored_exception", 64'(exception), 64'(1));
    issue(32'd7, 32'hFFFF_FFFD, 1'b0, lat);
    chk("b2b_result",  64'(result), 64'hFFFF_FFEB);
    chk("b2b_latency", 64'(lat),    64'(run_cycles(32'hFFFF_FFFD) + 1));

    // Reset in the middle of RUN.
    operand_a  = 32'd9;
    operand_b  = 32'h5555_5555;
    ctrl_start = 1'b1;
    @(negedge clock);
    ctrl_start = 1'b0;
    repeat (8) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy",       64'(busy),       64'(0));
    chk("midrst_result_rdy", 64'(result_rdy), 64'(0));
    chk("midrst_result",     64'(result),     64'(0));
    chk("midrst_exception",  64'(exception),  64'(0));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    issue(32'd5, 32'd5, 1'b0, lat);
    chk("5x5_result",  64'(result), 64'd25);
    chk("5x5_latency", 64'(lat),    64'(run_cycles(32'd5) + 1));

    @(negedge clock);
    issue(32'd5, 32'd1, 1'b0, lat);
    chk("5x1_result", 64'(result), 64'd5);
`ifdef MULT_EARLY_TERM_EN
    chk("5x1_latency", 64'(lat), 64'(3));
`else
    chk("5x1_latency", 64'(lat), 64'(17));
`endif

    // Randomized operations with gaps, back-to-back starts and dropped starts.
    for (int n = 0; n < 150; n++) begin
      issue(pick(), pick(), 1'b1, lat);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
